// File: rtl/msi_fab_avalon_bridge_n.sv
// Fabric-to-Avalon-MM bridge: per-channel drop FIFOs, round-robin arbiter, one outstanding
// Avalon transaction. Define MSI_FAB_WR_ACK_EN to return an add-bus ack for every write.
module msi_fab_avalon_bridge_n #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_CH*(16+ADDR_W+DATA_W)-1:0]  fab_drop_bus,
    input  logic [NUM_CH-1:0]                     fab_drop_vld,
    output logic [NUM_CH-1:0]                     fab_drop_rdy,
    output logic [(16+ADDR_W+DATA_W)-1:0]         fab_add_bus,
    output logic                                  fab_add_vld,
    input  logic                                  fab_add_rdy,
    output logic [ADDR_W-1:0]                     av_address,
    output logic                                  av_read,
    output logic                                  av_write,
    output logic [DATA_W-1:0]                     av_writedata,
    input  logic                                  av_waitrequest,
    input  logic [DATA_W-1:0]                     av_readdata,
    input  logic                                  av_readdatavalid
);
    localparam int FAB_W = 16 + ADDR_W + DATA_W;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    logic [FAB_W-1:0]  fifo_head [NUM_CH];
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [FAB_W-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
            logic [CNT_W-1:0] count_q, count_d;
            logic             rdy_q;
            logic             push;

            assign push = fab_drop_vld[gi] & rdy_q;

            always_comb begin
                count_d = count_q;
                if (push && !pop[gi]) begin
                    count_d = count_q + 1'b1;
                end else if (!push && pop[gi]) begin
                    count_d = count_q - 1'b1;
                end
            end

            // rdy is the registered "not full" of the count that will be visible next cycle
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    rdy_q    <= 1'b1;
                end else begin
                    if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
                    count_q <= count_d;
                    rdy_q   <= (count_d != CNT_W'(FIFO_DEPTH));
                end
            end

            always_ff @(posedge clk) begin
                if (push) mem_q[wr_ptr_q] <= fab_drop_bus[gi*FAB_W +: FAB_W];
            end

            assign fifo_head[gi]    = mem_q[rd_ptr_q];
            assign fifo_empty[gi]   = (count_q == '0);
            assign fab_drop_rdy[gi] = rdy_q;
        end
    endgenerate

    state_t              state_q;
    logic [CH_W-1:0]     rr_q;
    logic [CH_W-1:0]     win_q;
    logic                op_q;
    logic [6:0]          tag_q;
    logic [ADDR_W-1:0]   av_address_q;
    logic [DATA_W-1:0]   av_writedata_q;
    logic                av_read_q, av_write_q;
    logic                add_vld_q;
    logic [FAB_W-1:0]    add_bus_q;

    logic                grant_vld;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W-1:0]     scan_idx;
    logic [FAB_W-1:0]    head;
    logic                unused_chan_field;

    // First non-empty channel at or after the round-robin pointer
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (!grant_vld && !fifo_empty[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (state_q == IDLE && grant_vld) pop[grant_idx] = 1'b1;
    end

    assign head = fifo_head[grant_idx];
    // The incoming channel field is replaced by the physical index in responses
    assign unused_chan_field = ^head[FAB_W-9 -: 8];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rr_q           <= '0;
            win_q          <= '0;
            op_q           <= 1'b0;
            tag_q          <= '0;
            av_address_q   <= '0;
            av_writedata_q <= '0;
            av_read_q      <= 1'b0;
            av_write_q     <= 1'b0;
            add_vld_q      <= 1'b0;
            add_bus_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        op_q           <= head[FAB_W-1];
                        tag_q          <= head[FAB_W-2 -: 7];
                        win_q          <= grant_idx;
                        av_address_q   <= head[DATA_W +: ADDR_W];
                        av_writedata_q <= head[DATA_W-1:0];
                        av_read_q      <= head[FAB_W-1];
                        av_write_q     <= !head[FAB_W-1];
                        rr_q           <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!av_waitrequest) begin
                        av_read_q  <= 1'b0;
                        av_write_q <= 1'b0;
                        if (op_q) begin
                            state_q <= WAIT_RD;
                        end else begin
`ifdef MSI_FAB_WR_ACK_EN
                            add_bus_q <= {1'b0, tag_q, 8'(win_q), av_address_q, {DATA_W{1'b0}}};
                            add_vld_q <= 1'b1;
                            state_q   <= RESP;
`else
                            state_q   <= IDLE;
`endif
                        end
                    end
                end
                WAIT_RD: begin
                    if (av_readdatavalid) begin
                        add_bus_q <= {1'b1, tag_q, 8'(win_q), av_address_q, av_readdata};
                        add_vld_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (fab_add_rdy) begin
                        add_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign av_address   = av_address_q;
    assign av_writedata = av_writedata_q;
    assign av_read      = av_read_q;
    assign av_write     = av_write_q;
    assign fab_add_vld  = add_vld_q;
    assign fab_add_bus  = add_bus_q;

endmodule
